stack_ctrl: RTL and testbench

Sequencing controller for the CPU's 64-entry × 36-bit data stack. It accepts one stack operation at a time through a valid/ready handshake: push, drop, dup, swap, over, nip or replace. Top and next are cached in registers so the control unit sees them combinationally; lower entries live in an internal synchronous RAM. It detects overflow and underflow and holds them as sticky error flags for the control unit.

---
 rtl/stack_ctrl_if.sv | 29 ++
 rtl/stack_ctrl.sv | 165 ++++++++++++++++
 tb/tb_stack_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_ctrl_if.sv
// Operation/status bundle between the control unit (master) and the
// data-stack controller (slave).
interface stack_ctrl_if #(
  parameter int WIDTH      = 36,
  parameter int DEPTH_LOG2 = 6
);
  logic                  op_valid;
  logic                  op_ready;
  logic [2:0]            op;
  logic [WIDTH-1:0]      D;
  logic [WIDTH-1:0]      top;
  logic [WIDTH-1:0]      next;
  logic [DEPTH_LOG2:0]   depth;
  logic                  empty;
  logic                  full;
  logic                  err_ovf;
  logic                  err_unf;
  logic                  err_clr;

  modport master (
    output op_valid, op, D, err_clr,
    input  op_ready, top, next, depth, empty, full, err_ovf, err_unf
  );

  modport slave (
    input  op_valid, op, D, err_clr,
    output op_ready, top, next, depth, empty, full, err_ovf, err_unf
  );
endinterface

// File: rtl/stack_ctrl.sv
// Data-stack sequencing controller: top/next cached in registers, deeper
// entries in a synchronous RAM. Removing an element from depth > 2 costs one
// extra REFILL cycle to fetch the new second element from RAM.
module stack_ctrl #(
  parameter int WIDTH      = 36,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic         clk,
  input  logic         rst,
  stack_ctrl_if.slave  bus
);
  localparam int DW  = DEPTH_LOG2 + 1;
  localparam int AW  = DEPTH_LOG2;
  localparam int CAP = 2 ** DEPTH_LOG2;

  localparam logic [DW-1:0] CAP_D = DW'(CAP);
  localparam logic [DW-1:0] ONE   = DW'(1);
  localparam logic [DW-1:0] TWO   = DW'(2);
  localparam logic [DW-1:0] THREE = DW'(3);

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_PUSH    = 3'd1;
  localparam logic [2:0] OP_DROP    = 3'd2;
  localparam logic [2:0] OP_DUP     = 3'd3;
  localparam logic [2:0] OP_SWAP    = 3'd4;
  localparam logic [2:0] OP_OVER    = 3'd5;
  localparam logic [2:0] OP_NIP     = 3'd6;
  localparam logic [2:0] OP_REPLACE = 3'd7;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  top_q, top_d;
  logic [WIDTH-1:0]  next_q, next_d;
  logic [DW-1:0]     depth_q, depth_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_unf_q, err_unf_d;

  // Spill/refill RAM for entries 3..depth (deepest at address 0)
  logic [WIDTH-1:0]  mem_q [0:CAP-1];
  logic [WIDTH-1:0]  rd_data_q;
  logic              ram_we, ram_re;
  logic [AW-1:0]     ram_waddr, ram_raddr;

  logic              set_ovf, set_unf;
  logic [WIDTH-1:0]  push_val;
  logic              push_min_ok;

  // Spill goes just above the current RAM contents; refill reads the new
  // second element, which sits one below the old spill position.
  assign ram_waddr = AW'(depth_q - TWO);
  assign ram_raddr = AW'(depth_q - THREE);

  // Next-state, cache updates, RAM strobes and error setting for one op
  always_comb begin
    state_d     = state_q;
    top_d       = top_q;
    next_d      = next_q;
    depth_d     = depth_q;
    set_ovf     = 1'b0;
    set_unf     = 1'b0;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    push_val    = bus.D;
    push_min_ok = 1'b1;

    case (state_q)
      IDLE: begin
        if (bus.op_valid) begin
          case (bus.op)
            OP_PUSH, OP_DUP, OP_OVER: begin
              if (bus.op == OP_DUP) begin
                push_val    = top_q;
                push_min_ok = (depth_q >= ONE);
              end else if (bus.op == OP_OVER) begin
                push_val    = next_q;
                push_min_ok = (depth_q >= TWO);
              end
              if (depth_q == CAP_D) begin
                set_ovf = 1'b1;
              end else if (!push_min_ok) begin
                set_unf = 1'b1;
              end else begin
                ram_we  = (depth_q >= TWO);
                next_d  = top_q;
                top_d   = push_val;
                depth_d = depth_q + ONE;
              end
            end
            OP_SWAP: begin
              if (depth_q < TWO) begin
                set_unf = 1'b1;
              end else begin
                top_d  = next_q;
                next_d = top_q;
              end
            end
            OP_REPLACE: begin
              if (depth_q < ONE) set_unf = 1'b1;
              else               top_d   = bus.D;
            end
            OP_DROP, OP_NIP: begin
              if (depth_q < ((bus.op == OP_DROP) ? ONE : TWO)) begin
                set_unf = 1'b1;
              end else begin
                if (bus.op == OP_DROP) top_d = next_q;
                depth_d = depth_q - ONE;
                if (depth_q > TWO) begin
                  ram_re  = 1'b1;
                  state_d = REFILL;
                end else begin
                  next_d = '0;
                end
              end
            end
            default: ; // OP_NOP
          endcase
        end
      end
      REFILL: begin
        next_d  = rd_data_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A flag being set in the same cycle as a clear stays set
    err_ovf_d = set_ovf | (err_ovf_q & ~bus.err_clr);
    err_unf_d = set_unf | (err_unf_q & ~bus.err_clr);
  end

  // State, cache and flag registers; reset may abort a refill in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      top_q     <= '0;
      next_q    <= '0;
      depth_q   <= '0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      top_q     <= top_d;
      next_q    <= next_d;
      depth_q   <= depth_d;
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
    end
  end

  // RAM: one write and one registered read port, contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we) mem_q[ram_waddr] <= next_q;
    if (ram_re) rd_data_q <= mem_q[ram_raddr];
  end

  assign bus.op_ready = (state_q == IDLE);
  assign bus.top      = top_q;
  assign bus.next     = next_q;
  assign bus.depth    = depth_q;
  assign bus.empty    = (depth_q == '0);
  assign bus.full     = (depth_q == CAP_D);
  assign bus.err_ovf  = err_ovf_q;
  assign bus.err_unf  = err_unf_q;
endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: directed scenarios plus randomized op streams,
// all checked against a queue-based model of the stack.
module tb_stack_ctrl;
  localparam int W   = 36;
  localparam int DL  = 6;
  localparam int CAP = 64;

  localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, DROP = 3'd2, DUP = 3'd3;
  localparam logic [2:0] SWAP = 3'd4, OVER = 3'd5, NIP = 3'd6, REPL = 3'd7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  stack_ctrl_if #(.WIDTH(W), .DEPTH_LOG2(DL)) sif ();

  stack_ctrl #(.WIDTH(W), .DEPTH_LOG2(DL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: queue with the top of stack at the back
  logic [W-1:0] mq[$];
  bit           m_ovf = 1'b0;
  bit           m_unf = 1'b0;
  bit           m_refill = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] m_top();
    return (mq.size() >= 1) ? mq[mq.size()-1] : '0;
  endfunction

  function automatic logic [W-1:0] m_next();
    return (mq.size() >= 2) ? mq[mq.size()-2] : '0;
  endfunction

  task automatic model_apply(input logic [2:0] o, input logic [W-1:0] d, input bit clr);
    int n;
    bit so, su;
    logic [W-1:0] tmp;
    n = mq.size();
    so = 1'b0;
    su = 1'b0;
    m_refill = 1'b0;
    case (o)
      PUSH: if (n == CAP) so = 1'b1; else mq.push_back(d);
      DUP:  if (n == CAP) so = 1'b1; else if (n < 1) su = 1'b1; else mq.push_back(mq[n-1]);
      OVER: if (n == CAP) so = 1'b1; else if (n < 2) su = 1'b1; else mq.push_back(mq[n-2]);
      SWAP: if (n < 2) su = 1'b1;
            else begin tmp = mq[n-1]; mq[n-1] = mq[n-2]; mq[n-2] = tmp; end
      REPL: if (n < 1) su = 1'b1; else mq[n-1] = d;
      DROP: if (n < 1) su = 1'b1;
            else begin m_refill = (n > 2); void'(mq.pop_back()); end
      NIP:  if (n < 2) su = 1'b1;
            else begin m_refill = (n > 2); mq.delete(n-2); end
      default: ;
    endcase
    m_ovf = so | (m_ovf & ~clr);
    m_unf = su | (m_unf & ~clr);
  endtask

  task automatic check_state(input bit skip_next);
    check_val("top", sif.top, m_top());
    if (!skip_next) check_val("next", sif.next, m_next());
    check_val("depth", sif.depth, mq.size());
    check_val("empty", sif.empty, mq.size() == 0);
    check_val("full", sif.full, mq.size() == CAP);
    check_val("err_ovf", sif.err_ovf, m_ovf);
    check_val("err_unf", sif.err_unf, m_unf);
  endtask

  // Issue one op, then check the post-accept state and any refill cycle
  task automatic issue(input logic [2:0] o, input logic [W-1:0] d, input bit clr);
    int waitc;
    waitc = 0;
    while (sif.op_ready !== 1'b1 && waitc < 8) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (sif.op_ready !== 1'b1) check_val("ready_timeout", sif.op_ready, 1);
    sif.op_valid = 1'b1;
    sif.op       = o;
    sif.D        = d;
    sif.err_clr  = clr;
    model_apply(o, d, clr);
    @(posedge clk); #1;
    sif.op_valid = 1'b0;
    sif.op       = NOP;
    sif.err_clr  = 1'b0;
    $display("op=%0d d=0x%0h clr=%0d -> depth=%0d top=0x%0h next=0x%0h ready=%0d ovf=%0d unf=%0d",
             o, d, clr, sif.depth, sif.top, sif.next, sif.op_ready, sif.err_ovf, sif.err_unf);
    check_val("op_ready", sif.op_ready, !m_refill);
    check_state(m_refill);
    if (m_refill) begin
      @(posedge clk); #1;
      check_val("refill_next", sif.next, m_next());
      check_val("refill_ready", sif.op_ready, 1);
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (mq.size() > 0 && guard < 2*CAP) begin
      issue(DROP, '0, 1'b0);
      guard++;
    end
  endtask

  initial begin
    logic [63:0] r;
    logic [2:0]  o;

    sif.op_valid = 1'b0;
    sif.op       = NOP;
    sif.D        = '0;
    sif.err_clr  = 1'b0;

    // Reset and check idle outputs
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_val("rst_depth", sif.depth, 0);
    check_val("rst_empty", sif.empty, 1);
    check_val("rst_top", sif.top, 0);
    check_val("rst_next", sif.next, 0);
    check_val("rst_ready", sif.op_ready, 1);
    check_val("rst_ovf", sif.err_ovf, 0);
    check_val("rst_unf", sif.err_unf, 0);

    // Push 1..4, then drop three times
    for (int i = 1; i <= 4; i++) issue(PUSH, W'(i), 1'b0);
    check_val("p4_top", sif.top, 4);
    check_val("p4_next", sif.next, 3);
    check_val("p4_depth", sif.depth, 4);
    issue(DROP, '0, 1'b0);
    issue(DROP, '0, 1'b0);
    check_val("d2_top", sif.top, 2);
    check_val("d2_next", sif.next, 1);
    issue(DROP, '0, 1'b0);
    check_val("d3_top", sif.top, 1);
    check_val("d3_next", sif.next, 0);
    drain();

    // Stack manipulation words from top=A, next=B
    issue(PUSH, W'('hB), 1'b0);
    issue(PUSH, W'('hA), 1'b0);
    issue(SWAP, '0, 1'b0);
    check_val("swap_top", sif.top, 'hB);
    check_val("swap_next", sif.next, 'hA);
    issue(OVER, '0, 1'b0);
    check_val("over_top", sif.top, 'hA);
    check_val("over_next", sif.next, 'hB);
    check_val("over_depth", sif.depth, 3);
    issue(NIP, '0, 1'b0);
    check_val("nip_top", sif.top, 'hA);
    check_val("nip_next", sif.next, 'hA);
    check_val("nip_depth", sif.depth, 2);
    issue(DUP, '0, 1'b0);
    issue(REPL, W'('h5), 1'b0);
    check_val("repl_top", sif.top, 'h5);
    drain();

    // Fill to capacity, overflow, then drain in order
    for (int i = 0; i < CAP; i++) issue(PUSH, W'(i), 1'b0);
    check_val("cap_full", sif.full, 1);
    issue(PUSH, W'(99), 1'b0);
    check_val("ovf_flag", sif.err_ovf, 1);
    check_val("ovf_top", sif.top, 63);
    check_val("ovf_depth", sif.depth, 64);
    for (int i = 0; i < CAP; i++) begin
      issue(DROP, '0, 1'b0);
      check_val("drain_top", sif.top, (i < CAP-1) ? 62 - i : 0);
    end
    check_val("drain_empty", sif.empty, 1);

    // Underflow and sticky-flag clearing
    issue(NOP, '0, 1'b1);
    issue(DROP, '0, 1'b0);
    check_val("unf_flag", sif.err_unf, 1);
    check_val("unf_depth", sif.depth, 0);
    issue(PUSH, W'(3), 1'b0);
    issue(SWAP, '0, 1'b0);
    check_val("unf_sticky", sif.err_unf, 1);
    issue(NOP, '0, 1'b1);
    check_val("clr_unf", sif.err_unf, 0);
    issue(SWAP, '0, 1'b1);
    check_val("clr_set_wins", sif.err_unf, 1);
    issue(NOP, '0, 1'b1);

    // Reset in the middle of a refill
    issue(PUSH, W'(5), 1'b0);
    issue(PUSH, W'(6), 1'b0);
    sif.op_valid = 1'b1;
    sif.op       = DROP;
    @(posedge clk); #1;
    sif.op_valid = 1'b0;
    sif.op       = NOP;
    check_val("refill_busy", sif.op_ready, 0);
    rst = 1'b1;
    #1;
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    check_val("rr_depth", sif.depth, 0);
    check_val("rr_ready", sif.op_ready, 1);
    check_val("rr_top", sif.top, 0);
    check_val("rr_next", sif.next, 0);
    @(negedge clk);
    rst = 1'b0;
    issue(PUSH, W'(7), 1'b0);
    check_val("rr_push_top", sif.top, 7);
    check_val("rr_push_depth", sif.depth, 1);

    // Randomized: first push-heavy, then pop-heavy
    for (int k = 0; k < 600; k++) begin
      r = {$urandom(), $urandom()};
      o = 3'($urandom_range(0, 7));
      if (k < 300 && $urandom_range(0, 3) == 0) o = PUSH;
      if (k >= 300 && $urandom_range(0, 2) == 0) o = ($urandom_range(0, 1) == 0) ? DROP : NIP;
      issue(o, r[W-1:0], $urandom_range(0, 9) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
